// File: rtl/ai_shot_master.sv
//==============================================================================
// Module   : ai_shot_master
// Purpose  : Avalon-MM master that bridges the game controller to the ai
//            targeting slave. On a shot request it snapshots the board, writes
//            miss map, hit map and ships into the slave, starts it, reads back
//            the chosen cell, validates it and reports row/column.
// Ports    : clock, reset_n          - clock / async active-low reset
//            req                     - one-cycle shot request
//            miss_map, hit_map       - fired-cell maps, bit i = cell i
//            ships_left              - bit k = ship k afloat
//            busy                    - request in progress
//            shot_valid, shot_index,
//            shot_row, shot_col      - validated shot (pulse + held data)
//            error                   - pulse on timeout or illegal result
//            avm_*                   - Avalon-MM master interface
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ai_shot_master #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int BOARD_CELLS    = 100
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic [BOARD_CELLS-1:0] miss_map,
    input  logic [BOARD_CELLS-1:0] hit_map,
    input  logic [4:0]             ships_left,
    output logic                   busy,
    output logic                   shot_valid,
    output logic [6:0]             shot_index,
    output logic [3:0]             shot_row,
    output logic [3:0]             shot_col,
    output logic                   error,
    output logic [1:0]             avm_address,
    output logic                   avm_write,
    output logic [BOARD_CELLS-1:0] avm_writedata,
    output logic                   avm_read,
    input  logic [103:0]           avm_readdata,
    input  logic                   avm_waitrequest
);

    localparam int         c_CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] c_CELLS = 7'(BOARD_CELLS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_MISS   = 3'd1,
        S_WR_HIT    = 3'd2,
        S_WR_SHIPS  = 3'd3,
        S_WR_START  = 3'd4,
        S_RD_RESULT = 3'd5,
        S_CHECK     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [BOARD_CELLS-1:0] r_miss;
    logic [BOARD_CELLS-1:0] r_hit;
    logic [4:0]             r_ships;
    logic [6:0]             r_idx;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_busy;
    logic                   r_valid;
    logic                   r_error;
    logic [6:0]             r_shot_index;
    logic [3:0]             r_shot_row;
    logic [3:0]             r_shot_col;

    logic                   w_xfer;
    logic                   w_done;
    logic                   w_stall;
    logic                   w_timeout;
    logic                   w_write;
    logic                   w_read;
    logic [1:0]             w_addr;
    logic [BOARD_CELLS-1:0] w_wdata;
    logic [BOARD_CELLS-1:0] w_fired;
    logic                   w_legal;
    logic [3:0]             w_row;
    logic [6:0]             w_row_x10;
    logic [3:0]             w_col;
    logic                   w_unused;

    // Only the low seven result bits carry the cell index.
    assign w_unused = &{1'b0, avm_readdata[103:7]};

    assign w_xfer    = (r_state == S_WR_MISS)  || (r_state == S_WR_HIT) ||
                       (r_state == S_WR_SHIPS) || (r_state == S_WR_START) ||
                       (r_state == S_RD_RESULT);
    assign w_done    = w_xfer && !avm_waitrequest;
    assign w_stall   = w_xfer &&  avm_waitrequest;
    // The stall that would make the count reach TIMEOUT_CYCLES aborts the transfer.
    assign w_timeout = w_stall && (r_cnt == c_CW'(TIMEOUT_CYCLES - 1));

    // Legality: index on the board and cell not yet fired.
    assign w_fired = r_miss | r_hit;
    assign w_legal = (r_idx < c_CELLS) && !w_fired[r_idx];

    // Divide-by-10 as a compare chain against the row boundaries.
    always_comb begin
        w_row = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (r_idx >= 7'(k * 10)) begin
                w_row = 4'(k);
            end
        end
    end

    assign w_row_x10 = {w_row, 3'b000} + {2'b00, w_row, 1'b0};
    assign w_col     = 4'(r_idx - w_row_x10);

    // Next-state and bus drive; bus fields depend on state only, so they stay
    // stable for the whole duration of a stalled transfer.
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_read  = 1'b0;
        w_addr  = 2'd0;
        w_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (req) w_next = S_WR_MISS;
            end
            S_WR_MISS: begin
                w_write = 1'b1;
                w_addr  = 2'd1;
                w_wdata = r_miss;
                if (w_done) w_next = S_WR_HIT;
            end
            S_WR_HIT: begin
                w_write = 1'b1;
                w_addr  = 2'd2;
                w_wdata = r_hit;
                if (w_done) w_next = S_WR_SHIPS;
            end
            S_WR_SHIPS: begin
                w_write      = 1'b1;
                w_addr       = 2'd3;
                w_wdata[4:0] = r_ships;
                if (w_done) w_next = S_WR_START;
            end
            S_WR_START: begin
                w_write = 1'b1;
                if (w_done) w_next = S_RD_RESULT;
            end
            S_RD_RESULT: begin
                w_read = 1'b1;
                if (w_done) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = w_legal ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_miss       <= '0;
            r_hit        <= '0;
            r_ships      <= 5'd0;
            r_idx        <= 7'd0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_error      <= 1'b0;
            r_shot_index <= 7'd0;
            r_shot_row   <= 4'd0;
            r_shot_col   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            r_error <= 1'b0;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_stall) begin
                r_cnt <= r_cnt + c_CW'(1);
            end

            if ((r_state == S_IDLE) && req) begin
                r_miss  <= miss_map;
                r_hit   <= hit_map;
                r_ships <= ships_left;
                r_busy  <= 1'b1;
            end

            if ((r_state == S_RD_RESULT) && w_done) begin
                r_idx <= avm_readdata[6:0];
            end

            if (r_state == S_CHECK) begin
                r_busy <= 1'b0;
                if (w_legal) begin
                    r_shot_index <= r_idx;
                    r_shot_row   <= w_row;
                    r_shot_col   <= w_col;
                    r_valid      <= 1'b1;
                end else begin
                    r_error <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
            end
        end
    end

    assign busy          = r_busy;
    assign shot_valid    = r_valid;
    assign shot_index    = r_shot_index;
    assign shot_row      = r_shot_row;
    assign shot_col      = r_shot_col;
    assign error         = r_error;
    assign avm_address   = w_addr;
    assign avm_write     = w_write;
    assign avm_writedata = w_wdata;
    assign avm_read      = w_read;

endmodule

`default_nettype wire

// File: doc/ai_shot_master.md
Name: ai_shot_master

Overview:
- Avalon-MM master sitting directly upstream of the ai targeting slave; bridges the game controller to it.
- On a shot request it snapshots the board state, writes it into the ai slave, starts the computation and waits for it.
- It then reads back the chosen cell index, converts it to row/column and hands a validated shot to the game controller.

Parameters:
- TIMEOUT_CYCLES, 4096, max consecutive cycles any single bus transfer may stall on avm_waitrequest before abort.
- BOARD_CELLS, 100, cells on the 10x10 board; the index is row*10+col.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  one-cycle shot request from game FSM.
- miss_map  in  100  bit i = cell i fired and missed.
- hit_map  in  100  bit i = cell i fired and hit.
- ships_left  in  5  bit k = ship k still afloat.
- busy  out  1  high from accepted req until shot_valid/error.
- shot_valid  out  1  one-cycle pulse, shot outputs valid.
- shot_index  out  7  chosen cell 0..99.
- shot_row  out  4  shot_index / 10.
- shot_col  out  4  shot_index % 10.
- error  out  1  one-cycle pulse on timeout or illegal result.
- avm_address  out  2  slave register select.
- avm_write  out  1  write strobe.
- avm_writedata  out  100  write data; ships use bits [4:0], upper bits zero.
- avm_read  out  1  read strobe.
- avm_readdata  in  104  slave result; chosen index in [6:0].
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - busy, shot_valid, error, avm_write and avm_read = 0.
  - avm_address = 0, avm_writedata = 0.
  - shot_index, shot_row and shot_col = 0.
  - Timeout counter = 0.
  - Reset asserted mid-transfer drops all strobes immediately; no transfer is completed.
- Slave register map:
  - addr 1: miss map.
  - addr 2: hit map.
  - addr 3: ships.
  - addr 0 write: start.
  - addr 0 read: result. The slave holds waitrequest high until the computation is done.
- Bus rules:
  - address, writedata and the strobe are held stable while avm_waitrequest=1.
  - A transfer completes on the rising edge where the strobe=1 and avm_waitrequest=0.
  - Read data is sampled on that same edge; there is no readdatavalid.
  - Never more than one strobe high at a time.
- FSM states: IDLE, WR_MISS, WR_HIT, WR_SHIPS, WR_START, RD_RESULT, CHECK, DONE.
- IDLE:
  - req=1 latches miss_map, hit_map and ships_left into snapshot registers, sets busy and moves to WR_MISS.
  - req while busy is ignored (not queued).
- WR_MISS (addr 1, miss snapshot) -> WR_HIT (addr 2, hit snapshot) -> WR_SHIPS (addr 3, {95'b0, ships}) -> WR_START (addr 0, data 0) -> RD_RESULT (addr 0, read).
  - Each state advances only on transfer completion.
  - The strobe for the next state is asserted in the cycle immediately after completion. Minimum 1 cycle per transfer, with no idle gap between transfers.
- CHECK: one cycle.
  - idx = readdata[6:0].
  - Row/col are computed by a registered divide-by-10 (LUT or subtract chain), ready at the end of CHECK.
  - Illegal if idx >= BOARD_CELLS, or if (miss|hit)[idx]=1 (cell already fired).
  - Illegal -> error pulse, outputs unchanged, IDLE.
  - Legal -> DONE.
- DONE:
  - shot_index, shot_row and shot_col are registered.
  - shot_valid pulses 1 cycle, busy clears in the same cycle, then IDLE.
  - Shot outputs hold until the next successful shot.
- Timeout:
  - Counter resets on every state change and increments each cycle the strobe is high with waitrequest=1.
  - Reaching TIMEOUT_CYCLES drops the strobe, pulses error, clears busy and returns to IDLE.
- Latency, zero-wait slave: req edge -> shot_valid = 7 cycles (5 transfers + CHECK + DONE).
- ships_left=0: still issued normally; the slave result is checked like any other.

Test Plan:
- Zero-wait slave, all maps 0, ships=5'b11111, readdata[6:0]=45:
  - writes observed in order addr1=0, addr2=0, addr3=0x1F, addr0.
  - shot_valid 7 cycles after req, row=4, col=5, index=45.
- Slave stalls 3 cycles on each transfer:
  - address, data and strobe stay stable throughout each stall.
  - shot_valid 22 cycles after req.
  - readdata=99 -> row=9, col=9.
- Readdata=23 with hit_map bit 23 set:
  - error pulses, shot_valid stays 0, shot_index retains its previous value.
- Readdata=100:
  - error pulses, busy=0 next cycle.
- TIMEOUT_CYCLES=16, waitrequest stuck high on the addr 0 read:
  - avm_read drops after 16 stalled cycles, error pulses once.
  - A new req is then accepted.
- Extra req pulses while busy are ignored. reset_n pulsed low during WR_HIT: all strobes low at once, outputs at reset values.
  - After reset release a fresh req completes normally (readdata=0 -> row 0, col 0).
